// File: rtl/rf_multiport.sv
// Multi-ported register file: two combinational reads, two clocked writes,
// optional write-through bypass and zero register, plus a one-entry-per-cycle clear engine.
module rf_multiport #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 32,
  parameter int                ADDR_W    = $clog2(DEPTH),
  parameter bit                ZERO_REG  = 1'b1,
  parameter bit                BYPASS    = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_conflict
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;
  logic              conflict_q, conflict_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic idle;
  logic eff_a;
  logic eff_b;
  logic clearing;

  // A write only counts when the engine is idle and it does not target the zero register.
  always_comb begin
    idle       = (state_q == ST_IDLE);
    clearing   = (state_q == ST_CLEAR);
    eff_a      = wr_en_a && idle && !(ZERO_REG && (wr_addr_a == '0));
    eff_b      = wr_en_b && idle && !(ZERO_REG && (wr_addr_b == '0));
    conflict_d = eff_a && eff_b && (wr_addr_a == wr_addr_b);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      conflict_q <= conflict_d;
    end
  end

  // Per-entry update: the sweep owns the array while busy; B overrides A on a shared address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clearing && (idx_q == ADDR_W'(i))) begin
          mem_q[i] <= RESET_VAL;
        end else if (eff_b && (wr_addr_b == ADDR_W'(i))) begin
          mem_q[i] <= wr_data_b;
        end else if (eff_a && (wr_addr_a == ADDR_W'(i))) begin
          mem_q[i] <= wr_data_a;
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] arr_val,
    input logic              busy,
    input logic              hit_a,
    input logic              hit_b,
    input logic [DATA_W-1:0] data_a,
    input logic [DATA_W-1:0] data_b
  );
    logic [DATA_W-1:0] res;
    if (ZERO_REG && (addr == '0)) begin
      res = '0;
    end else if (busy) begin
      res = RESET_VAL;
    end else if (BYPASS && hit_b) begin
      res = data_b;
    end else if (BYPASS && hit_a) begin
      res = data_a;
    end else begin
      res = arr_val;
    end
    return res;
  endfunction

  always_comb begin
    rd_data1 = read_sel(rd_addr1, mem_q[rd_addr1], clearing,
                        eff_a && (wr_addr_a == rd_addr1),
                        eff_b && (wr_addr_b == rd_addr1),
                        wr_data_a, wr_data_b);
    rd_data2 = read_sel(rd_addr2, mem_q[rd_addr2], clearing,
                        eff_a && (wr_addr_a == rd_addr2),
                        eff_b && (wr_addr_b == rd_addr2),
                        wr_data_a, wr_data_b);
  end

  assign clr_busy    = clearing;
  assign clr_done    = done_q;
  assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: a bypass and a non-bypass instance share stimulus and
// are compared every cycle against an array-level model of the register file.
module tb_rf_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr_a, wr_addr_b;
  logic [31:0] wr_data_a, wr_data_b;
  logic        wr_en_a, wr_en_b, clr_req;

  logic [31:0] rd1_y, rd2_y, rd1_n, rd2_n;
  logic        busy_y, done_y, conf_y, busy_n, done_n, conf_n;

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0;
  int n;

  logic [31:0] m_mem [32];
  bit          m_busy, m_done, m_conf;
  int          m_pos;

  always #5 clk = ~clk;

  rf_multiport #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1), .RESET_VAL(32'h0)) dut_byp (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1_y), .rd_data2(rd2_y),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .clr_req(clr_req), .clr_busy(busy_y), .clr_done(done_y), .wr_conflict(conf_y)
  );

  rf_multiport #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0), .RESET_VAL(32'h0)) dut_nobyp (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1_n), .rd_data2(rd2_n),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .clr_req(clr_req), .clr_busy(busy_n), .clr_done(done_n), .wr_conflict(conf_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp);
    bit ea, eb;
    ea = wr_en_a && !m_busy && (wr_addr_a != 5'd0);
    eb = wr_en_b && !m_busy && (wr_addr_b != 5'd0);
    if (a == 5'd0) return 32'h0;
    if (m_busy) return 32'h0;
    if (byp && eb && (wr_addr_b == a)) return wr_data_b;
    if (byp && ea && (wr_addr_a == a)) return wr_data_a;
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_conf = 1'b0;
    m_pos  = 0;
  endtask

  task automatic model_step();
    bit ea, eb;
    if (!rst) begin
      model_reset();
      return;
    end
    ea = wr_en_a && !m_busy && (wr_addr_a != 5'd0);
    eb = wr_en_b && !m_busy && (wr_addr_b != 5'd0);
    m_conf = ea && eb && (wr_addr_a == wr_addr_b);
    m_done = 1'b0;
    if (m_busy) begin
      m_mem[m_pos] = 32'h0;
      m_pos++;
      if (m_pos == 32) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      if (ea) m_mem[wr_addr_a] = wr_data_a;
      if (eb) m_mem[wr_addr_b] = wr_data_b;
      if (clr_req) begin
        m_busy = 1'b1;
        m_pos  = 0;
      end
    end
  endtask

  // Mid-cycle compare of every output against the model, then advance one clock.
  task automatic cycle();
    @(negedge clk);
    chk("rd1_byp",   rd1_y, model_rd(rd_addr1, 1'b1));
    chk("rd2_byp",   rd2_y, model_rd(rd_addr2, 1'b1));
    chk("rd1_nobyp", rd1_n, model_rd(rd_addr1, 1'b0));
    chk("rd2_nobyp", rd2_n, model_rd(rd_addr2, 1'b0));
    chk("busy",      32'(busy_y), 32'(m_busy));
    chk("busy_nb",   32'(busy_n), 32'(m_busy));
    chk("done",      32'(done_y), 32'(m_done));
    chk("conflict",  32'(conf_y), 32'(m_conf));
    if (done_y) done_cnt++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en_a = 1'b0; wr_en_b = 1'b0; clr_req = 1'b0;
  endtask

  task automatic fill_index();
    for (int i = 1; i < 32; i++) begin
      wr_en_a = 1'b1; wr_addr_a = 5'(i); wr_data_a = 32'(i);
      rd_addr1 = 5'(i); rd_addr2 = 5'(i - 1);
      cycle();
    end
    wr_en_a = 1'b0;
  endtask

  task automatic measure_sweep(input string tag);
    n = 0;
    while (busy_y && n < 100) begin
      wr_en_a = 1'b1; wr_addr_a = 5'd9; wr_data_a = 32'hFF;
      rd_addr1 = 5'd9; rd_addr2 = 5'($urandom_range(0, 31));
      cycle();
      n++;
    end
    wr_en_a = 1'b0;
    chk(tag, 32'(n), 32'd32);
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    wr_addr_a = 5'd0; wr_addr_b = 5'd0; wr_data_a = 32'h0; wr_data_b = 32'h0;
    model_reset();
    repeat (2) cycle();

    rd_addr1 = 5'd0; rd_addr2 = 5'd5; #1;
    chk("rst_rd_a0", rd1_y, 32'h0);
    chk("rst_rd_a5", rd2_y, 32'h0);
    rd_addr1 = 5'd31; #1;
    chk("rst_rd_a31", rd1_y, 32'h0);
    chk("rst_busy", 32'(busy_y), 32'h0);
    chk("rst_conf", 32'(conf_y), 32'h0);
    rst = 1'b1;
    cycle();

    wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'hDEADBEEF;
    cycle();
    wr_en_a = 1'b0; rd_addr1 = 5'd3; #1;
    chk("wr_rd3", rd1_y, 32'hDEADBEEF);
    wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'h1234; rd_addr1 = 5'd0; #1;
    chk("zero_byp", rd1_y, 32'h0);
    cycle();
    wr_en_a = 1'b0; #1;
    chk("zero_reg", rd1_y, 32'h0);

    wr_en_a = 1'b1; wr_addr_a = 5'd4; wr_data_a = 32'h55;
    cycle();
    wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'h11;
    wr_en_b = 1'b1; wr_addr_b = 5'd7; wr_data_b = 32'h22;
    rd_addr2 = 5'd7; #1;
    chk("byp_b_wins", rd2_y, 32'h22);
    chk("nobyp_old7", rd2_n, 32'h0);
    cycle();
    idle_inputs(); #1;
    chk("arr7", rd2_y, 32'h22);
    chk("conf_hi", 32'(conf_y), 32'h1);
    cycle();
    chk("conf_lo", 32'(conf_y), 32'h0);

    wr_en_a = 1'b1; wr_addr_a = 5'd4; wr_data_a = 32'hAA; rd_addr1 = 5'd4; #1;
    chk("nobyp_same", rd1_n, 32'h55);
    chk("byp_same",   rd1_y, 32'hAA);
    cycle();
    wr_en_a = 1'b0; #1;
    chk("nobyp_next", rd1_n, 32'hAA);

    fill_index();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    done_cnt = 0;
    measure_sweep("sweep_len");
    cycle();
    chk("done_pulses", 32'(done_cnt), 32'd1);
    rd_addr1 = 5'd9; #1;
    chk("drop_wr9", rd1_y, 32'h0);
    for (int i = 0; i < 32; i += 2) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(i + 1);
      cycle();
    end

    fill_index();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    repeat (10) cycle();
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_y), 32'h0);
    model_reset();
    repeat (2) cycle();
    rst = 1'b1;
    for (int i = 0; i < 32; i += 2) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(i + 1);
      cycle();
    end
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    measure_sweep("sweep_len2");

    for (int k = 0; k < 500; k++) begin
      wr_en_a   = 1'($urandom_range(0, 1));
      wr_en_b   = 1'($urandom_range(0, 1));
      wr_addr_a = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wr_addr_b = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wr_data_a = $urandom;
      wr_data_b = $urandom;
      rd_addr1  = ($urandom_range(0, 2) == 0) ? wr_addr_a : 5'($urandom_range(0, 31));
      rd_addr2  = ($urandom_range(0, 2) == 0) ? wr_addr_b : 5'($urandom_range(0, 31));
      clr_req   = ($urandom_range(0, 59) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
Parametrised register file for the CPU datapath. It has two asynchronous read ports, two synchronous write ports, optional write-through bypass and an optional hard-wired zero register. A sequential clear engine re-initialises the whole array one entry per cycle on request. It sits between decode (read) and writeback (write).

Parameters:
DATA_W, 32, width of each register in bits
DEPTH, 32, number of registers (power of two, >=4)
ADDR_W, $clog2(DEPTH), address width (derived; not overridden)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads
RESET_VAL, 0, value loaded into every entry by reset and by the clear engine

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
rd_addr1  input  ADDR_W  read port 1 address
rd_addr2  input  ADDR_W  read port 2 address
rd_data1  output  DATA_W  read port 1 data (combinational)
rd_data2  output  DATA_W  read port 2 data (combinational)
wr_en_a  input  1  write port A enable
wr_addr_a  input  ADDR_W  write port A address
wr_data_a  input  DATA_W  write port A data
wr_en_b  input  1  write port B enable
wr_addr_b  input  ADDR_W  write port B address
wr_data_b  input  DATA_W  write port B data
clr_req  input  1  start a full clear sweep (sampled in IDLE only)
clr_busy  output  1  high while the clear sweep is running
clr_done  output  1  one-cycle pulse in the cycle after the last entry is cleared
wr_conflict  output  1  registered; high the cycle after A and B both wrote the same effective address

Behaviour:
- Reset (rst=0, asynchronous):
  - all entries = RESET_VAL
  - FSM = IDLE, sweep index = 0
  - clr_busy = 0, clr_done = 0, wr_conflict = 0
  - if asserted mid-sweep, the sweep aborts immediately
- Write rules:
  - A write is effective when wr_en_x=1, the FSM is IDLE, and not (ZERO_REG=1 and addr==0).
  - Writes land on the rising edge, so data is visible to the array read path 1 cycle later.
  - If A and B are both effective to the same address, B wins.
  - In that same-address case, wr_conflict=1 in the next cycle only.
- Read rules:
  - Combinational, no latency.
  - ZERO_REG=1 and addr==0 -> read 0 regardless of any write or bypass.
  - Else if BYPASS=1 and an effective write this cycle matches addr -> return that write data; B has priority over A.
  - Else -> return the array contents.
  - While clr_busy=1, both read ports return RESET_VAL.
- Clear FSM:
  - IDLE: clr_req=1 -> go to CLEAR, index=0, clr_busy=1 from the next cycle.
  - CLEAR: each cycle, entry[index] = RESET_VAL and index++.
  - When index==DEPTH-1 is written, go to IDLE; clr_busy=0 and clr_done=1 in the next cycle.
  - A sweep takes exactly DEPTH cycles of clr_busy.
  - clr_req while busy is ignored (no restart, no queueing).
  - wr_en_a/b asserted while busy are dropped silently.
  - Writes presented in the same cycle clr_req is accepted (FSM still IDLE) do land, then get swept.
- Arithmetic: index is ADDR_W bits; it wraps naturally to 0 after DEPTH-1 but is reset to 0 on entry to CLEAR.
- No X on outputs after reset; out-of-range addresses cannot occur (DEPTH = 2^ADDR_W).

Test Plan:
- Reset then read: rst=0, RESET_VAL=0 -> rd_data1/2 = 0 at addresses 0, 5, 31; clr_busy=0, wr_conflict=0.
- Basic write/read: wr_en_a=1, addr=3, data=0xDEADBEEF; next cycle rd_addr1=3 -> 0xDEADBEEF. Write to addr 0 with data 0x1234 -> reads 0 (ZERO_REG=1).
- Bypass and priority: in the same cycle, A writes addr 7 = 0x11 and B writes addr 7 = 0x22, with rd_addr2=7 -> rd_data2=0x22 combinationally. Next cycle: array holds 0x22 and wr_conflict=1; the cycle after, wr_conflict=0.
- Clear sweep: fill all 32 entries with their index value, then pulse clr_req.
  - clr_busy must be high for exactly 32 cycles; reads return 0 during the sweep.
  - Writes of 0xFF to addr 9 during the sweep are dropped.
  - clr_done pulses once at the end; afterwards every entry reads 0.
- Reset mid-sweep: start the sweep, assert rst=0 at sweep cycle 10 -> clr_busy=0 immediately and all entries = RESET_VAL. A clr_req after release starts a fresh 32-cycle sweep.
- BYPASS=0 build: A writes addr 4 = 0xAA with rd_addr1=4 in the same cycle -> old value returned; 0xAA is returned the next cycle.
